// File: rtl/pc_pkg.sv
// Shared encodings and default address constants for the program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_J    = 3'd2,
    NPC_JR   = 3'd3,
    NPC_ERET = 3'd4
  } npc_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LEZ = 3'd2,
    BR_GTZ = 3'd3,
    BR_LTZ = 3'd4,
    BR_GEZ = 3'd5
  } br_cond_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_if.sv
// Decoder/register-file facing bundle of the PC unit; slave is the PC unit side.
interface pc_if import pc_pkg::*; #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            intr;
  npc_op_e         npc_op;
  br_cond_e        br_cond;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] epc;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] link_addr;
  logic            br_taken;
  logic            addr_err;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;
  logic            ras_mismatch;

  modport master (
    output stall, intr, npc_op, br_cond, instr, rs_val, rt_val, epc, ras_push, ras_pop,
    input  pc, npc, link_addr, br_taken, addr_err, ras_top, ras_valid, ras_mismatch
  );

  modport slave (
    input  stall, intr, npc_op, br_cond, instr, rs_val, rt_val, epc, ras_push, ras_pop,
    output pc, npc, link_addr, br_taken, addr_err, ras_top, ras_valid, ras_mismatch
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: top pointer plus saturating count; overflow
// silently overwrites the oldest entry. Storage itself is not reset.
module pc_ras import pc_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            valid
);
  localparam int            PW      = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d, waddr_s;
  logic [PW:0]     cnt_q, cnt_d;
  logic            we_s;

  // Next pointer/count and write strobe; push+pop on a non-empty stack replaces the top.
  always_comb begin
    top_d   = top_q;
    cnt_d   = cnt_q;
    we_s    = 1'b0;
    waddr_s = top_q;
    if (en && push && pop && (cnt_q != '0)) begin
      we_s = 1'b1;
    end else if (en && push) begin
      we_s    = 1'b1;
      waddr_s = top_q + PTR_ONE;
      top_d   = top_q + PTR_ONE;
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (en && pop && (cnt_q != '0)) begin
      top_d = top_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      top_d = top_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata;
    end
  end

  assign top   = mem_q[top_q];
  assign valid = (cnt_q != '0);

endmodule

// File: rtl/pc_unit.sv
// Architectural PC register with next-PC selection, in-block branch compare,
// exception/eret redirection, stall hold and a return-address stack.
module pc_unit import pc_pkg::*; #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEFAULT_EXC_VECTOR),
  parameter int              RAS_DEPTH  = 4
) (
  input logic  clk,
  input logic  reset,
  pc_if.slave  bus
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_s, br_target_s, j_target_s, npc_s, ras_top_s;
  logic            cond_s, update_s, ras_en_s, addr_err_s, ras_valid_s;
  logic            unused_instr_s;

  assign pc_plus4_s     = pc_q + XLEN'(32'd4);
  assign br_target_s    = pc_plus4_s + {{(XLEN-18){bus.instr[15]}}, bus.instr[15:0], 2'b00};
  assign j_target_s     = {pc_plus4_s[XLEN-1:28], bus.instr[25:0], 2'b00};
  assign unused_instr_s = ^bus.instr[31:26];

  // Signed branch condition; rt only matters for EQ/NE.
  always_comb begin
    cond_s = 1'b0;
    case (bus.br_cond)
      BR_EQ:   cond_s = (bus.rs_val == bus.rt_val);
      BR_NE:   cond_s = (bus.rs_val != bus.rt_val);
      BR_LEZ:  cond_s = bus.rs_val[XLEN-1] || (bus.rs_val == '0);
      BR_GTZ:  cond_s = !bus.rs_val[XLEN-1] && (bus.rs_val != '0);
      BR_LTZ:  cond_s = bus.rs_val[XLEN-1];
      BR_GEZ:  cond_s = !bus.rs_val[XLEN-1];
      default: cond_s = 1'b0;
    endcase
  end

  // Next-PC priority: interrupt, eret, jr, j, taken branch, sequential.
  always_comb begin
    npc_s = pc_plus4_s;
    if (bus.intr) begin
      npc_s = EXC_VECTOR;
    end else begin
      case (bus.npc_op)
        NPC_ERET: npc_s = bus.epc;
        NPC_JR:   npc_s = bus.rs_val;
        NPC_J:    npc_s = j_target_s;
        NPC_BR: begin
          if (cond_s) begin
            npc_s = br_target_s;
          end else begin
            npc_s = pc_plus4_s;
          end
        end
        default:  npc_s = pc_plus4_s;
      endcase
    end
  end

  // Misaligned register-sourced target flag; the PC still loads it.
  always_comb begin
    addr_err_s = 1'b0;
    case (bus.npc_op)
      NPC_JR:   addr_err_s = (bus.rs_val[1:0] != 2'b00);
      NPC_ERET: addr_err_s = (bus.epc[1:0] != 2'b00);
      default:  addr_err_s = 1'b0;
    endcase
  end

  assign update_s = !bus.stall || bus.intr;
  assign ras_en_s = update_s && !bus.intr &&
                    ((bus.npc_op == NPC_J) || (bus.npc_op == NPC_JR));

  // PC load/hold decision.
  always_comb begin
    pc_d = pc_q;
    if (update_s) begin
      pc_d = npc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .en    (ras_en_s),
    .push  (bus.ras_push),
    .pop   (bus.ras_pop),
    .wdata (pc_plus4_s),
    .top   (ras_top_s),
    .valid (ras_valid_s)
  );

  assign bus.pc           = pc_q;
  assign bus.npc          = npc_s;
  assign bus.link_addr    = pc_plus4_s;
  assign bus.br_taken     = (bus.npc_op == NPC_BR) && cond_s;
  assign bus.addr_err     = addr_err_s;
  assign bus.ras_top      = ras_top_s;
  assign bus.ras_valid    = ras_valid_s;
  assign bus.ras_mismatch = bus.ras_pop && ras_valid_s && (ras_top_s != bus.rs_val);

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  pc_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .RAS_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall    = 1'b0;
    bus.intr     = 1'b0;
    bus.npc_op   = NPC_SEQ;
    bus.br_cond  = BR_EQ;
    bus.instr    = 32'h0000_0000;
    bus.rs_val   = 32'h0000_0000;
    bus.rt_val   = 32'h0000_0000;
    bus.epc      = 32'h0000_0000;
    bus.ras_push = 1'b0;
    bus.ras_pop  = 1'b0;
  endtask

  // Async reset pulse away from the clock edge; leaves the unit stalled at RESET_PC.
  task automatic hard_reset();
    @(negedge clk);
    idle();
    bus.stall = 1'b1;
    reset = 1'b1;
    #2;
    chk("async_reset_pc", bus.pc, 32'h0000_3000);
    chk("async_reset_ras_valid", 32'(bus.ras_valid), 32'd0);
    reset = 1'b0;
  endtask

  task automatic jr_step(input logic [31:0] tgt, input logic psh, input logic pp);
    @(negedge clk);
    idle();
    bus.npc_op   = NPC_JR;
    bus.rs_val   = tgt;
    bus.ras_push = psh;
    bus.ras_pop  = pp;
    tick();
  endtask

  initial begin
    logic [31:0] pop_exp [4];
    pop_exp = '{32'h0000_8004, 32'h0000_7004, 32'h0000_6004, 32'h0000_5004};

    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", bus.pc, 32'h0000_3000);
    chk("rst_npc", bus.npc, 32'h0000_3004);
    chk("rst_link", bus.link_addr, 32'h0000_3004);
    chk("rst_ras_valid", 32'(bus.ras_valid), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", bus.pc, 32'h0000_3000 + 32'(4 * i));
    end

    @(negedge clk);
    bus.stall = 1'b1;
    #1;
    chk("stall_npc", bus.npc, 32'h0000_3010);
    tick();
    chk("stall_pc1", bus.pc, 32'h0000_300C);
    tick();
    chk("stall_pc2", bus.pc, 32'h0000_300C);
    @(negedge clk);
    bus.stall = 1'b0;
    tick();
    chk("unstall_pc", bus.pc, 32'h0000_3010);

    @(negedge clk);
    bus.stall   = 1'b1;
    bus.npc_op  = NPC_BR;
    bus.br_cond = BR_EQ;
    bus.rs_val  = 32'd5;
    bus.rt_val  = 32'd5;
    bus.instr   = 32'h0000_FFFE;
    #1;
    chk("beq_npc", bus.npc, 32'h0000_300C);
    chk("beq_taken", 32'(bus.br_taken), 32'd1);
    bus.rt_val = 32'd6;
    #1;
    chk("beq_nt_npc", bus.npc, 32'h0000_3014);
    chk("beq_nt_taken", 32'(bus.br_taken), 32'd0);

    hard_reset();
    @(negedge clk);
    idle();
    tick();
    chk("post_reset_edge_pc", bus.pc, 32'h0000_3004);

    hard_reset();
    bus.npc_op  = NPC_BR;
    bus.br_cond = BR_LTZ;
    bus.rs_val  = 32'h8000_0000;
    bus.instr   = 32'h0000_0004;
    #1;
    chk("bltz_npc", bus.npc, 32'h0000_3014);
    bus.br_cond = BR_GEZ;
    #1;
    chk("bgez_npc", bus.npc, 32'h0000_3004);
    chk("bgez_taken", 32'(bus.br_taken), 32'd0);
    bus.br_cond = BR_LEZ;
    bus.rs_val  = 32'h0000_0000;
    #1;
    chk("blez_zero_npc", bus.npc, 32'h0000_3014);
    bus.br_cond = BR_GTZ;
    #1;
    chk("bgtz_zero_npc", bus.npc, 32'h0000_3004);
    bus.rs_val = 32'h0000_0001;
    #1;
    chk("bgtz_one_npc", bus.npc, 32'h0000_3014);
    bus.br_cond = BR_NE;
    bus.rs_val  = 32'd5;
    bus.rt_val  = 32'd6;
    #1;
    chk("bne_taken", 32'(bus.br_taken), 32'd1);
    bus.npc_op = NPC_SEQ;
    #1;
    chk("seq_not_taken", 32'(bus.br_taken), 32'd0);

    @(negedge clk);
    idle();
    bus.npc_op   = NPC_J;
    bus.instr    = 32'h0000_0100;
    bus.ras_push = 1'b1;
    #1;
    chk("jal_npc", bus.npc, 32'h0000_0400);
    tick();
    chk("jal_pc", bus.pc, 32'h0000_0400);
    chk("jal_ras_top", bus.ras_top, 32'h0000_3004);
    chk("jal_ras_valid", 32'(bus.ras_valid), 32'd1);
    @(negedge clk);
    idle();
    bus.npc_op  = NPC_JR;
    bus.ras_pop = 1'b1;
    bus.rs_val  = 32'h0000_3004;
    #1;
    chk("jr_match", 32'(bus.ras_mismatch), 32'd0);
    tick();
    chk("jr_pc", bus.pc, 32'h0000_3004);
    chk("jr_ras_empty", 32'(bus.ras_valid), 32'd0);

    hard_reset();
    @(negedge clk);
    idle();
    bus.npc_op   = NPC_J;
    bus.instr    = 32'h0000_0100;
    bus.ras_push = 1'b1;
    tick();
    @(negedge clk);
    idle();
    bus.npc_op  = NPC_JR;
    bus.ras_pop = 1'b1;
    bus.rs_val  = 32'h0000_3008;
    #1;
    chk("jr_mismatch", 32'(bus.ras_mismatch), 32'd1);
    tick();
    chk("jr_mis_pc", bus.pc, 32'h0000_3008);
    chk("jr_mis_ras_empty", 32'(bus.ras_valid), 32'd0);

    hard_reset();
    jr_step(32'h0000_5000, 1'b1, 1'b0);
    jr_step(32'h0000_6000, 1'b1, 1'b0);
    jr_step(32'h0000_7000, 1'b1, 1'b0);
    jr_step(32'h0000_8000, 1'b1, 1'b0);
    jr_step(32'h0000_9000, 1'b1, 1'b0);
    chk("ovf_pc", bus.pc, 32'h0000_9000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      bus.npc_op  = NPC_JR;
      bus.ras_pop = 1'b1;
      bus.rs_val  = pop_exp[i];
      #1;
      chk("pop_top", bus.ras_top, pop_exp[i]);
      chk("pop_match", 32'(bus.ras_mismatch), 32'd0);
      tick();
    end
    chk("pop_all_empty", 32'(bus.ras_valid), 32'd0);
    @(negedge clk);
    idle();
    bus.npc_op  = NPC_JR;
    bus.ras_pop = 1'b1;
    bus.rs_val  = 32'h0000_6000;
    #1;
    chk("underflow_mismatch", 32'(bus.ras_mismatch), 32'd0);
    tick();
    chk("underflow_empty", 32'(bus.ras_valid), 32'd0);
    chk("underflow_pc", bus.pc, 32'h0000_6000);

    jr_step(32'h0000_7000, 1'b1, 1'b0);
    chk("push1_top", bus.ras_top, 32'h0000_6004);
    jr_step(32'h0000_7004, 1'b1, 1'b1);
    chk("pushpop_top", bus.ras_top, 32'h0000_7004);
    chk("pushpop_valid", 32'(bus.ras_valid), 32'd1);
    jr_step(32'h0000_7200, 1'b0, 1'b1);
    chk("pushpop_count_kept", 32'(bus.ras_valid), 32'd0);
    jr_step(32'h0000_7300, 1'b1, 1'b1);
    chk("pushpop_empty_top", bus.ras_top, 32'h0000_7204);
    chk("pushpop_empty_valid", 32'(bus.ras_valid), 32'd1);

    @(negedge clk);
    idle();
    bus.stall    = 1'b1;
    bus.npc_op   = NPC_J;
    bus.instr    = 32'h0000_0200;
    bus.ras_push = 1'b1;
    tick();
    chk("stall_j_pc", bus.pc, 32'h0000_7300);
    chk("stall_j_ras_top", bus.ras_top, 32'h0000_7204);

    @(negedge clk);
    idle();
    bus.stall   = 1'b1;
    bus.intr    = 1'b1;
    bus.npc_op  = NPC_JR;
    bus.ras_pop = 1'b1;
    bus.rs_val  = 32'h0000_7204;
    #1;
    chk("intr_npc", bus.npc, 32'h0000_4180);
    tick();
    chk("intr_pc", bus.pc, 32'h0000_4180);
    chk("intr_ras_valid", 32'(bus.ras_valid), 32'd1);
    chk("intr_ras_top", bus.ras_top, 32'h0000_7204);

    @(negedge clk);
    idle();
    bus.npc_op = NPC_ERET;
    bus.epc    = 32'h0000_3022;
    #1;
    chk("eret_npc", bus.npc, 32'h0000_3022);
    chk("eret_addr_err", 32'(bus.addr_err), 32'd1);
    tick();
    chk("eret_pc", bus.pc, 32'h0000_3022);

    @(negedge clk);
    idle();
    bus.npc_op = NPC_JR;
    bus.rs_val = 32'hFFFF_FFFC;
    #1;
    chk("jr_aligned_addr_err", 32'(bus.addr_err), 32'd0);
    tick();
    @(negedge clk);
    idle();
    #1;
    chk("wrap_npc", bus.npc, 32'h0000_0000);
    chk("wrap_link", bus.link_addr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit with next-PC selection, generalised branch conditions, exception/eret redirection, stall handling and a small return-address stack (RAS). It sits at the front of the datapath: it holds the architectural PC feeding instruction memory and computes the next PC from the decoder's control and the register-file operands. It supersedes the combinational next-PC logic. Branch comparison now happens inside the block instead of relying on an external zero flag.

## Interface
- XLEN, 32, datapath width (≥32; jump region uses bits XLEN-1:28)
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VECTOR, 32'h0000_4180, interrupt/exception entry address
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC and RAS this cycle
- intr  in  1  take exception vector (overrides everything, including stall)
- npc_op  in  3  npc_op_e: SEQ, BR, J, JR, ERET
- br_cond  in  3  br_cond_e: EQ, NE, LEZ, GTZ, LTZ, GEZ
- instr  in  32  current instruction (imm16 = [15:0], target26 = [25:0])
- rs_val, rt_val  in  XLEN  register operands
- epc  in  XLEN  return address for ERET
- ras_push  in  1  current J/JR is a linking jump (jal/jalr)
- ras_pop  in  1  current JR is a return (jr $ra)
- pc  out  XLEN  registered current PC
- npc  out  XLEN  combinational next PC
- link_addr  out  XLEN  pc+4
- br_taken  out  1  BR op with condition true
- addr_err  out  1  JR/ERET target with [1:0] ≠ 0
- ras_top, ras_valid  out  XLEN, 1  RAS top entry, stack non-empty
- ras_mismatch  out  1  ras_pop && ras_valid && ras_top ≠ rs_val

## Operation
- pc_plus4 = pc + 4, modulo 2^XLEN (wraps silently).
- Branch target = pc_plus4 + (sext(imm16) << 2). Conditions are signed: EQ rs==rt, NE rs!=rt, LEZ rs≤0, GTZ rs>0, LTZ rs<0, GEZ rs≥0. rt_val is ignored except for EQ/NE.
- Jump target = {pc_plus4[XLEN-1:28], target26, 2'b00}.
- npc priority: intr → EXC_VECTOR; else ERET → epc; else JR → rs_val; else J → jump target; else BR and taken → branch target; else pc_plus4. Undefined npc_op encodings behave as SEQ.
- addr_err is informational only. The PC still loads the misaligned target; CP0 raises the exception via intr on the following cycle.
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH). Operations are qualified by an update condition, defined under Timing.
  - Push: write link_addr at top+1, advance top, count saturates at RAS_DEPTH. Overflow overwrites the oldest entry silently.
  - Pop with count>0: retreat top, count−1.
  - Pop with count=0: no-op.
  - Push and pop together: overwrite the top entry with link_addr; pointer and count are unchanged. If count=0 this behaves as a push.
- ras_push/ras_pop are ignored unless npc_op is J or JR.
- ras_valid = (count≠0). ras_top is the entry at top; its value is don't-care when ras_valid=0.

## Timing
- Reset (asynchronous): pc=RESET_PC, count=0, top=0, ras_valid=0. During reset all combinational outputs are derived from pc=RESET_PC. RAS storage contents are not reset.
- Update condition (update) = !stall || intr. On each rising edge with update=1: pc ← npc.
- RAS changes only when update=1 && !intr.
- Latency: npc is valid in the same cycle as its inputs; pc reflects it one edge later.
- While stall=1 and intr=0: pc, pointer, count and contents hold. npc, br_taken and ras_mismatch still evaluate combinationally.
- Reset asserted mid-stall or mid-sequence: state returns to reset values immediately. The first edge after deassertion loads npc computed from RESET_PC.

## Structure
- Package pc_pkg holds:
  - npc_op_e (3-bit: SEQ=0, BR=1, J=2, JR=3, ERET=4)
  - br_cond_e (3-bit: EQ=0, NE=1, LEZ=2, GTZ=3, LTZ=4, GEZ=5)
  - default RESET_PC/EXC_VECTOR constants
- Sub-module pc_ras (parameters XLEN, RAS_DEPTH): storage, top pointer and count, with push/pop/en inputs and top/valid outputs. pc_unit holds the PC register, target adders, condition compare and select.

## Test plan
- Reset, then 3 edges of SEQ → pc 0x3000, 0x3004, 0x3008, 0x300C. stall=1 for 2 edges → pc holds 0x300C and npc=0x3010.
- At pc=0x3010: BR EQ rs=rt=5, imm16=0xFFFE → npc=0x300C, br_taken=1. Same inputs with rt=6 → npc=0x3014, br_taken=0.
- BR LTZ rs=0x8000_0000, imm16=0x0004 at pc=0x3000 → npc=0x3014. GEZ with the same rs → npc=0x3004.
- J with push at pc=0x3000 and target26=0x0000100 → npc=0x0000_0400, ras_top=0x3004. JR with pop, rs=0x3004 → ras_mismatch=0 and count returns to 0. Repeat with rs=0x3008 → ras_mismatch=1.
- RAS_DEPTH=4: 5 pushes with link_addr values A..E → 4 pops return E, D, C, B. Then ras_valid=0, and a 5th pop leaves the state unchanged.
- stall=1 with intr=1 → pc=0x4180 next edge and the RAS is unchanged. ERET with epc=0x3022 → pc=0x3022 and addr_err=1.
